// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, opcodes, flag positions and FSM states for the ALU execute unit
package alu_pkg;
    localparam int WIDTH   = 16;
    localparam int SHAMT_W = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    localparam int FLG_Z = 0;
    localparam int FLG_C = 1;
    localparam int FLG_V = 2;
    localparam int FLG_N = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    function automatic logic [3:0] mk_flags(input logic n, input logic v, input logic c, input logic z);
        logic [3:0] f;
        f        = '0;
        f[FLG_N] = n;
        f[FLG_V] = v;
        f[FLG_C] = c;
        f[FLG_Z] = z;
        return f;
    endfunction
endpackage

// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: request/response handshake bundle between requester and ALU execute unit
interface alu_exec_unit_if;
    import alu_pkg::*;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [2:0]       req_op;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic [3:0]       rsp_flags;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_flags
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_flags
    );
endinterface

// File: rtl/alu_core_comb.sv
// alu_core_comb: single-cycle ADD/SUB/logic/NOT datapath with flag generation
module alu_core_comb
    import alu_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic           c;
    logic           v;

    // Widened add/sub expose carry and borrow; overflow from operand/result sign bits
    always_comb begin
        sum    = {1'b0, a} + {1'b0, b};
        diff   = {1'b0, a} - {1'b0, b};
        result = '0;
        c      = 1'b0;
        v      = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum[WIDTH-1:0];
                c      = sum[WIDTH];
                v      = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                result = diff[WIDTH-1:0];
                c      = ~diff[WIDTH];
                v      = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOT:  result = ~a;
            default: result = '0;
        endcase
        flags = mk_flags(result[WIDTH-1], v, c, result == '0);
    end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked ALU responder with a bit-serial shifter and registered result/flags
module alu_exec_unit
    import alu_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    alu_exec_unit_if.slave bus
);
    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               c_q, c_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [3:0]         flags_q, flags_d;
    logic               req_ready_q, req_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   core_result;
    logic [3:0]         core_flags;
    logic               accept;
    logic               is_shift;

    alu_core_comb u_core (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (core_result),
        .flags  (core_flags)
    );

    assign bus.req_ready  = req_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = result_q;
    assign bus.rsp_flags  = flags_q;

    // Next-state: latch on accept, compute or shift one bit per cycle, hold response until consumed
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        c_d      = c_q;
        result_d = result_q;
        flags_d  = flags_q;
        accept   = req_ready_q && bus.req_valid;
        is_shift = (bus.req_op == OP_SHL) || (bus.req_op == OP_SHR);
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    a_d     = bus.req_a;
                    b_d     = bus.req_b;
                    op_d    = bus.req_op;
                    sh_d    = bus.req_a;
                    cnt_d   = bus.req_b[SHAMT_W-1:0];
                    c_d     = 1'b0;
                    state_d = is_shift ? ST_SHIFT : ST_EXEC;
                end
            end
            ST_EXEC: begin
                result_d = core_result;
                flags_d  = core_flags;
                state_d  = ST_RESP;
            end
            ST_SHIFT: begin
                if (cnt_q != '0) begin
                    sh_d  = (op_q == OP_SHL) ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};
                    c_d   = (op_q == OP_SHL) ? sh_q[WIDTH-1] : sh_q[0];
                    cnt_d = cnt_q - SHAMT_W'(1);
                end else begin
                    result_d = sh_q;
                    flags_d  = mk_flags(sh_q[WIDTH-1], 1'b0, c_q, sh_q == '0);
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
    end

    // State and output registers; reset abandons any in-flight operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            sh_q        <= '0;
            cnt_q       <= '0;
            c_q         <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            c_q         <= c_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and random checks of alu_exec_unit against an arithmetic reference model
module tb_alu_exec_unit;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    alu_exec_unit_if bus ();

    alu_exec_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic; latency counted in clock edges from accept edge
    // to the first edge at which the requester samples rsp_valid=1
    function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                                  output logic [15:0] r, output logic [3:0] f, output int lat);
        int   sa, sb, s, amt;
        logic c, v;
        sa  = $signed(a);
        sb  = $signed(b);
        amt = int'(b[3:0]);
        c   = 1'b0;
        v   = 1'b0;
        lat = 2;
        case (op)
            3'd0: begin
                r = a + b;
                c = (int'(a) + int'(b)) > 65535;
                s = sa + sb;
                v = (s > 32767) || (s < -32768);
            end
            3'd1: begin
                r = a - b;
                c = a >= b;
                s = sa - sb;
                v = (s > 32767) || (s < -32768);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin
                r   = a << amt;
                c   = (amt == 0) ? 1'b0 : a[16-amt];
                lat = amt + 2;
            end
            3'd6: begin
                r   = a >> amt;
                c   = (amt == 0) ? 1'b0 : a[amt-1];
                lat = amt + 2;
            end
            default: r = ~a;
        endcase
        f = {r[15], v, c, r == 16'h0};
    endfunction

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] op, input int hold);
        logic [15:0] er;
        logic [3:0]  ef;
        int          el, lat;
        model(a, b, op, er, ef, el);
        for (int i = 0; i < 40 && !bus.req_ready; i++) @(negedge clk);
        check({tag, "_ready"}, bus.req_ready, 1'b1);
        bus.req_valid = 1'b1;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_op    = op;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_a     = 16'($urandom);
        bus.req_b     = 16'($urandom);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!bus.rsp_valid && lat < 40);
        check({tag, "_rsp_valid"}, bus.rsp_valid, 1'b1);
        check({tag, "_result"}, bus.rsp_result, er);
        check({tag, "_flags"}, bus.rsp_flags, ef);
        check({tag, "_latency"}, lat + 1, el);
        for (int i = 0; i < hold; i++) begin
            if (i == 4) begin
                bus.req_valid = 1'b1;
                bus.req_op    = 3'd2;
            end
            if (i == 5) bus.req_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check({tag, "_hold_result"}, bus.rsp_result, er);
            check({tag, "_hold_flags"}, bus.rsp_flags, ef);
            check({tag, "_hold_ready"}, bus.req_ready, 1'b0);
            check({tag, "_hold_valid"}, bus.rsp_valid, 1'b1);
        end
        bus.rsp_ready = 1'b1;
        if (hold > 0) bus.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b0;
        check({tag, "_idle_ready"}, bus.req_ready, 1'b1);
        check({tag, "_idle_valid"}, bus.rsp_valid, 1'b0);
        if (hold > 0) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, "_ignored_valid"}, bus.rsp_valid, 1'b0);
            check({tag, "_ignored_ready"}, bus.req_ready, 1'b1);
        end
    endtask

    initial begin
        logic seen;
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_req_ready", bus.req_ready, 1'b1);
        check("reset_rsp_valid", bus.rsp_valid, 1'b0);
        check("reset_result", bus.rsp_result, 16'h0);
        check("reset_flags", bus.rsp_flags, 4'h0);
        rst = 1'b0;
        @(negedge clk);

        bus.req_valid = 1'b1;
        bus.req_a     = 16'h0001;
        bus.req_b     = 16'd15;
        bus.req_op    = 3'd5;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("shift_busy_ready", bus.req_ready, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_rsp_valid", bus.rsp_valid, 1'b0);
        check("midrst_req_ready", bus.req_ready, 1'b1);
        check("midrst_result", bus.rsp_result, 16'h0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            seen = seen | bus.rsp_valid;
        end
        check("midrst_no_response", seen, 1'b0);

        run_op("add_1_1", 16'h0001, 16'h0001, 3'd0, 0);
        run_op("add_wrap", 16'hFFFF, 16'h0001, 3'd0, 0);
        run_op("sub_ovf", 16'h8000, 16'h0001, 3'd1, 0);
        run_op("sub_zero", 16'h0001, 16'h0001, 3'd1, 0);
        run_op("sub_neg", 16'h0000, 16'h0001, 3'd1, 0);
        run_op("and", 16'h00F0, 16'h0FF0, 3'd2, 0);
        run_op("or", 16'h00F0, 16'h0FF0, 3'd3, 0);
        run_op("xor", 16'h00F0, 16'h0FF0, 3'd4, 0);
        run_op("not", 16'h00F0, 16'h0FF0, 3'd7, 0);
        run_op("shl_1", 16'h8001, 16'h0001, 3'd5, 0);
        run_op("shr_15", 16'h8000, 16'h000F, 3'd6, 0);
        run_op("shl_0", 16'h8001, 16'h0010, 3'd5, 0);
        run_op("backpressure", 16'h7FFF, 16'h0001, 3'd0, 10);
        run_op("after_bp", 16'h1234, 16'h0F0F, 3'd4, 0);

        for (int n = 0; n < 40; n++) begin
            run_op("rand", 16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
